unidad_busqueda: RTL

UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/unidad_busqueda_if.sv | 10 +
 rtl/unidad_busqueda_registro_if_id.sv | 40 ++++
 rtl/unidad_busqueda.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: reset PC default, halt opcode and the
// fetch FSM state encoding. DETENIDO only exists when FETCH_HALT_EN is defined.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] HALT_OPCODE  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    INICIO,
    PEDIR,
    RETENER
`ifdef FETCH_HALT_EN
    , DETENIDO
`endif
  } estado_t;

endpackage

// File: rtl/unidad_busqueda_if.sv
// Instruction-memory request/ack bus. The fetch unit is the master.
interface unidad_busqueda_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_dato;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_dato);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_dato);
endinterface

// File: rtl/unidad_busqueda_registro_if_id.sv
// IF/ID pipeline register. flush/kill clear the valid bit with top priority,
// stall holds everything, otherwise valid follows load (a bubble when no word).
module registro_if_id (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        kill_i,
  input  logic        load_i,
  input  logic [31:0] dato_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valido_o
);

  logic [31:0] instr_q, pc_q;
  logic        valido_q;

  // Valid/data update; data only moves on an accepted load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      pc_q     <= '0;
      valido_q <= 1'b0;
    end else begin
      if (flush_i || kill_i) valido_q <= 1'b0;
      else if (!stall_i)     valido_q <= load_i;
      if (load_i && !flush_i && !kill_i) begin
        instr_q <= dato_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign instr_o  = instr_q;
  assign pc_o     = pc_q;
  assign valido_o = valido_q;

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: PC, fetch FSM, stall hold buffer and redirect
// tracking. Optional halt-on-opcode behaviour is enabled by FETCH_HALT_EN.
module unidad_busqueda
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               salto_tomado,
  input  logic [31:0]        dir_salto,
  unidad_busqueda_if.master  imem,
  output logic [31:0]        instr_id,
  output logic [31:0]        pc_id,
  output logic               valido_id,
  output logic               halted
);

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;          // redirect seen during outstanding request
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_dato_q, buf_dato_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic        carga, kill;
  logic [31:0] dato_id, pc_carga, pc_sig;

  assign pc_sig = pc_q + PC_INC;        // wraps modulo 2^32

  // State, PC, redirect and hold-buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIO;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      tgt_q      <= '0;
      buf_dato_q <= '0;
      buf_pc_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      tgt_q      <= tgt_d;
      buf_dato_q <= buf_dato_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  // Next-state: a redirect always wins over returned data, flush drops the
  // word but still consumes it, stall parks the word in the hold buffer.
  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    buf_dato_d = buf_dato_q;
    buf_pc_d   = buf_pc_q;
    carga      = 1'b0;
    kill       = 1'b0;
    dato_id    = imem.imem_dato;
    pc_carga   = pc_sig;
    case (estado_q)
      INICIO: begin
        estado_d = PEDIR;
        if (salto_tomado) begin
          pc_d = dir_salto;
          kill = 1'b1;
        end
      end
      PEDIR: begin
        if (imem.imem_ack) begin
          if (salto_tomado) begin
            pc_d   = dir_salto;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = tgt_q;
            pend_d = 1'b0;
          end
`ifdef FETCH_HALT_EN
          else if (imem.imem_dato == HALT_OPCODE) begin
            estado_d = DETENIDO;
          end
`endif
          else if (flush) begin
            pc_d = pc_sig;
          end else if (stall) begin
            buf_dato_d = imem.imem_dato;
            buf_pc_d   = pc_sig;
            estado_d   = RETENER;
          end else begin
            carga = 1'b1;
            pc_d  = pc_sig;
          end
        end else if (salto_tomado) begin
          pend_d = 1'b1;
          tgt_d  = dir_salto;
        end
      end
      RETENER: begin
        if (salto_tomado) begin
          pc_d     = dir_salto;
          kill     = 1'b1;
          estado_d = PEDIR;
        end else if (flush) begin
          pc_d     = buf_pc_q;
          estado_d = PEDIR;
        end else if (!stall) begin
          carga    = 1'b1;
          dato_id  = buf_dato_q;
          pc_carga = buf_pc_q;
          pc_d     = buf_pc_q;
          estado_d = PEDIR;
        end
      end
`ifdef FETCH_HALT_EN
      DETENIDO: estado_d = DETENIDO;
`endif
      default: estado_d = INICIO;
    endcase
  end

  assign imem.imem_req  = (estado_q == PEDIR);
  assign imem.imem_addr = pc_q;

`ifdef FETCH_HALT_EN
  assign halted = (estado_q == DETENIDO);
`else
  assign halted = 1'b0;
`endif

  registro_if_id u_if_id (
    .clk      (clk),
    .reset    (reset),
    .stall_i  (stall),
    .flush_i  (flush),
    .kill_i   (kill),
    .load_i   (carga),
    .dato_i   (dato_id),
    .pc_i     (pc_carga),
    .instr_o  (instr_id),
    .pc_o     (pc_id),
    .valido_o (valido_id)
  );

endmodule
